cla_pipe_addsub: RTL

//  Parametrised two-level carry-lookahead adder/subtractor with a 2-stage valid/ready pipeline.

---
 rtl/cla_pipe_addsub.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cla_pipe_addsub.sv
// Two-level carry-lookahead adder/subtractor with a 2-stage valid/ready pipeline.
// Stage 1 forms bit and group generate/propagate terms; stage 2 resolves carries, sum and flags.
module cla_pipe_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NG = WIDTH / GROUP;

    if ((WIDTH % GROUP != 0) || (NG > GROUP)) begin : g_param_check
        $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP and WIDTH/GROUP <= GROUP");
    end

    // Handshake
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic accept, s2_adv;

    always_comb begin
        s2_adv     = s1_valid_q & (~s2_valid_q | out_ready);
        in_ready   = ~s1_valid_q | s2_adv;
        accept     = in_valid & in_ready;
        s1_valid_d = accept | (s1_valid_q & ~s2_adv);
        s2_valid_d = (~s2_valid_q | out_ready) ? s1_valid_q : s2_valid_q;
    end

    // Stage 1: operand prep and first-level lookahead
    logic [WIDTH-1:0] bb, g, p;
    logic [NG-1:0]    gg, gp;
    logic             c0;
    logic             term1;

    always_comb begin
        bb    = sub ? ~b : b;
        c0    = sub | cin;
        g     = a & bb;
        p     = a ^ bb;
        term1 = 1'b0;
        for (int k = 0; k < NG; k++) begin
            gg[k] = 1'b0;
            gp[k] = 1'b1;
            for (int j = 0; j < GROUP; j++) begin
                term1 = g[k*GROUP + j];
                for (int m = j + 1; m < GROUP; m++) begin
                    term1 = term1 & p[k*GROUP + m];
                end
                gg[k] = gg[k] | term1;
                gp[k] = gp[k] & p[k*GROUP + j];
            end
        end
    end

    // Bit generates are kept alongside propagates so in-group carries can be formed in stage 2.
    logic [WIDTH-1:0] g_q, p_q;
    logic [NG-1:0]    gg_q, gp_q;
    logic             c0_q, a_msb_q, bb_msb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            g_q        <= '0;
            p_q        <= '0;
            gg_q       <= '0;
            gp_q       <= '0;
            c0_q       <= 1'b0;
            a_msb_q    <= 1'b0;
            bb_msb_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                g_q      <= g;
                p_q      <= p;
                gg_q     <= gg;
                gp_q     <= gp;
                c0_q     <= c0;
                a_msb_q  <= a[WIDTH-1];
                bb_msb_q <= bb[WIDTH-1];
            end
        end
    end

    // Stage 2: second-level lookahead, in-group carries, sum and flags (all flat SOP, no ripple)
    logic [NG:0]      gc;
    logic [WIDTH-1:0] carry, sum_d;
    logic             ovf_d, term2, acc2;

    always_comb begin
        term2 = 1'b0;
        acc2  = 1'b0;
        gc[0] = c0_q;
        for (int k = 0; k < NG; k++) begin
            term2 = c0_q;
            for (int m = 0; m <= k; m++) term2 = term2 & gp_q[m];
            acc2 = term2;
            for (int i = 0; i <= k; i++) begin
                term2 = gg_q[i];
                for (int m = i + 1; m <= k; m++) term2 = term2 & gp_q[m];
                acc2 = acc2 | term2;
            end
            gc[k+1] = acc2;
        end
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < GROUP; j++) begin
                term2 = gc[k];
                for (int m = 0; m < j; m++) term2 = term2 & p_q[k*GROUP + m];
                acc2 = term2;
                for (int i = 0; i < j; i++) begin
                    term2 = g_q[k*GROUP + i];
                    for (int m = i + 1; m < j; m++) term2 = term2 & p_q[k*GROUP + m];
                    acc2 = acc2 | term2;
                end
                carry[k*GROUP + j] = acc2;
            end
        end
        sum_d = p_q ^ carry;
        ovf_d = (a_msb_q == bb_msb_q) & (sum_d[WIDTH-1] != a_msb_q);
    end

    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_adv) begin
                sum_q  <= sum_d;
                cout_q <= gc[NG];
                ovf_q  <= ovf_d;
                zero_q <= ~|sum_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
